alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Initiator side of the basic ALU operand/op_code/result interface. It accepts ALU commands over a valid/ready stream and buffers them in a small FIFO. Each command is driven onto the ALU ports and held for a fixed settle time, then the ALU result is captured and returned in order over a valid/ready response stream. It sits between a command source (sequencer or bus adapter) and the combinational basic ALU.

Parameters:
DATA_W, 8, operand/result width; matches the ALU.
DEPTH, 4, command FIFO depth; power of 2, at least 2.
SETTLE_CYCLES, 2, cycles operands are held on the ALU before the result is captured; at least 1.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept a command.
cmd_a  input  DATA_W  operand a.
cmd_b  input  DATA_W  operand b.
cmd_op  input  2  op code: 00 ADD, 01 SUB, 10 AND, 11 OR.
alu_a  output  DATA_W  operand a to the ALU, registered.
alu_b  output  DATA_W  operand b to the ALU, registered.
alu_op_code  output  2  op code to the ALU, registered.
alu_result  input  DATA_W  combinational ALU result.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  DATA_W  captured result.
rsp_op  output  2  op code of the command that produced the result.
busy  output  1  high when state is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; state forced to IDLE.
  - alu_a, alu_b, alu_op_code, rsp_result and rsp_op all reset to 0.
  - rsp_valid = 0; cmd_ready = 1 on the first cycle after reset.
  - Reset during DRIVE or RESP drops the in-flight command and any pending response.
- Command FIFO:
  - Push on cmd_valid && cmd_ready. cmd_ready = (count != DEPTH), taken from registered count only.
  - Push while full is ignored. A pop in the same cycle does not free the slot for that cycle.
  - Simultaneous push and pop when not full: count is unchanged; both operations take effect.
  - Pointers wrap modulo DEPTH.
- State machine (IDLE, DRIVE, RESP):
  - IDLE: if the FIFO is non-empty, pop the head and register {a, b, op} onto alu_a, alu_b, alu_op_code. Load settle counter = SETTLE_CYCLES and go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: ALU ports held stable; counter decrements each cycle. On the cycle the counter equals 1, capture alu_result into rsp_result and alu_op_code into rsp_op, set rsp_valid = 1, and go to RESP.
  - RESP: rsp_valid, rsp_result and rsp_op held stable until rsp_ready. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE.
  - A new pop never occurs in the handshake cycle; IDLE always lasts at least one cycle.
- ALU ports retain the last command's values between commands; they do not return to zero.
- Latency:
  - Command accepted at edge N into an empty FIFO with the issuer idle: ALU ports update at edge N+1; rsp_valid rises at edge N+1+SETTLE_CYCLES.
  - Throughput with rsp_ready tied high: one command per SETTLE_CYCLES+2 cycles.
- Arithmetic is performed by the ALU and is modulo 2^DATA_W: ADD wraps, SUB borrows wrap (5-10 = 251). The issuer only transports values.
- Responses are returned strictly in command order.

Optional Feature:
ALU_CHECK_EN:
- Defined:
  - An internal reference model computes the expected result from alu_a, alu_b and alu_op_code at capture.
  - Added output rsp_mismatch (1 bit) is registered alongside rsp_result and set when the captured result differs from the model.
  - Added output err_count (8 bits) increments once per mismatching response at capture and saturates at 255.
  - Both reset to 0.
- Undefined: neither port exists and no compare logic is built. All other behaviour is identical.

Test Plan:
1. Defaults; cmd 10+5, op 00, rsp_ready=1 -> alu ports 10/5/00 one cycle after accept; rsp_valid 3 cycles after accept; rsp_result=15, rsp_op=00.
2. cmds 255+1 (op 00) then 5-10 (op 01) back-to-back -> responses 0 then 251, in order; cmd_ready never drops.
3. cmds 0xAA&0xCC (op 10) then 0xAA|0xCC (op 11) -> rsp_result 0x88 then 0xEE.
4. rsp_ready=0; offer 6 cmds continuously -> cmds 1-5 accepted (one in flight, 4 queued); cmd_ready=0 from the cycle after the 5th accept; rsp_valid and rsp_result stable. Release rsp_ready -> 5 responses in order; the 6th cmd is then accepted.
5. Assert rst for one cycle mid-DRIVE with 2 cmds queued -> next cycle: rsp_valid=0, busy=0, cmd_ready=1, alu ports 0; no stale response ever appears.
6. ALU_CHECK_EN defined; testbench forces alu_result=0 for 7+3 -> rsp_mismatch=1, err_count=1. Next correct cmd -> rsp_mismatch=0, err_count stays 1.

Source files
------------

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a small FIFO, drives each onto the
// combinational ALU for SETTLE_CYCLES, captures the result and returns it in
// order over a valid/ready response stream.
// Optional build macro: ALU_CHECK_EN adds rsp_mismatch / err_count reference checking.
module alu_cmd_issuer #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op_code,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [1:0]        rsp_op,
`ifdef ALU_CHECK_EN
    output logic              rsp_mismatch,
    output logic [7:0]        err_count,
`endif
    output logic              busy
);

    localparam int unsigned PTR_W  = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int unsigned FILL_W = PTR_W + 1;
    localparam int unsigned CNT_W  = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [1:0]        op;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    cmd_t              mem_q [DEPTH];
    cmd_t              mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] count_q, count_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [1:0]        rsp_op_q, rsp_op_d;
    logic              push, pop;
    cmd_t              head;
`ifdef ALU_CHECK_EN
    logic              mismatch_q, mismatch_d;
    logic [7:0]        err_q, err_d;

    // Reference ALU: modulo 2^DATA_W arithmetic on the driven operands
    function automatic logic [DATA_W-1:0] alu_model(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic [1:0]        op);
        logic [DATA_W-1:0] r;
        unique case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction
`endif

    assign head = mem_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and output register inputs
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        pop          = 1'b0;
        push         = cmd_valid && cmd_ready_q;
`ifdef ALU_CHECK_EN
        mismatch_d   = mismatch_q;
        err_d        = err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != FILL_W'(0)) begin
                    pop      = 1'b1;
                    alu_a_d  = head.a;
                    alu_b_d  = head.b;
                    alu_op_d = head.op;
                    cnt_d    = CNT_W'(SETTLE_CYCLES);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    rsp_result_d = alu_result;
                    rsp_op_d     = alu_op_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
`ifdef ALU_CHECK_EN
                    mismatch_d = (alu_result != alu_model(alu_a_q, alu_b_q, alu_op_q));
                    if (mismatch_d && (err_q != 8'hFF)) begin
                        err_d = err_q + 8'(1);
                    end
`endif
                end
            end
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + FILL_W'(1);
            2'b01:   count_d = count_q - FILL_W'(1);
            default: count_d = count_q;
        endcase

        cmd_ready_d = (count_d != FILL_W'(DEPTH));
        busy_d      = (state_d != ST_IDLE) || (count_d != FILL_W'(0));
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
`ifdef ALU_CHECK_EN
            mismatch_q   <= 1'b0;
            err_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cnt_q        <= cnt_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
`ifdef ALU_CHECK_EN
            mismatch_q   <= mismatch_d;
            err_q        <= err_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op_code = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_op      = rsp_op_q;
`ifdef ALU_CHECK_EN
    assign rsp_mismatch = mismatch_q;
    assign err_count    = err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed commands, expected responses queued
// at accept time and checked by an independent response monitor.
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op_code;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [1:0] rsp_op;
    logic       busy;
`ifdef ALU_CHECK_EN
    logic       rsp_mismatch;
    logic [7:0] err_count;
`endif

    typedef struct {
        logic [7:0] res;
        logic [1:0] op;
        logic       mis;
        logic [7:0] err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic force_zero = 1'b0;
    logic [7:0] exp_err = 8'd0;

    logic       prev_hold = 1'b0;
    logic [7:0] prev_res  = 8'd0;
    logic [1:0] prev_op   = 2'd0;

    alu_cmd_issuer #(.DATA_W(8), .DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op_code (alu_op_code),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_op      (rsp_op),
`ifdef ALU_CHECK_EN
        .rsp_mismatch(rsp_mismatch),
        .err_count   (err_count),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU the issuer drives
    always_comb begin
        unique case (alu_op_code)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        if (force_zero) alu_result = 8'd0;
    end

    // Response monitor: hold check while stalled, scoreboard check on handshake
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                total++;
                if (!rsp_valid || rsp_result != prev_res || rsp_op != prev_op) begin
                    bad++;
                    $display("FAIL rsp_hold: got v=%0b res=%0d op=%0d, need v=1 res=%0d op=%0d",
                             rsp_valid, rsp_result, rsp_op, prev_res, prev_op);
                end
            end
            if (rsp_valid && rsp_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got res=%0d op=%0d, need no response", rsp_result, rsp_op);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_result != e.res || rsp_op != e.op) begin
                        bad++;
                        $display("FAIL rsp_data: got res=%0d op=%0d, need res=%0d op=%0d",
                                 rsp_result, rsp_op, e.res, e.op);
                    end
`ifdef ALU_CHECK_EN
                    total++;
                    if (rsp_mismatch != e.mis || err_count != e.err) begin
                        bad++;
                        $display("FAIL rsp_check: got mis=%0b err=%0d, need mis=%0b err=%0d",
                                 rsp_mismatch, err_count, e.mis, e.err);
                    end
`endif
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_res  = rsp_result;
            prev_op   = rsp_op;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    // Offer one command until accepted; queue its expected response at accept
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [7:0] res, input logic mis, output int waits);
        logic acc;
        exp_t e;
        waits     = 0;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        while (!acc && waits < 200) begin
            @(negedge clk);
            acc = cmd_ready;
            if (acc) begin
                if (mis && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                e.res = res;
                e.op  = op;
                e.mis = mis;
                e.err = exp_err;
                sb.push_back(e);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no accept, need accept within 200 cycles");
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rsp_valid || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy || rsp_valid || sb.size() != 0), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int stale;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_op    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu", {alu_a, alu_b, 6'd0, alu_op_code, 8'd0}, 32'd0);
        check("rst_rsp", {rsp_result, 6'd0, rsp_op}, 32'd0);
`ifdef ALU_CHECK_EN
        check("rst_check", {rsp_mismatch, err_count}, 32'd0);
`endif

        // 1: latency of a single command
        rsp_ready = 1'b1;
        send(8'd10, 8'd5, 2'b00, 8'd15, 1'b0, w);
        check("t1_alu_a_before", 32'(alu_a), 32'd0);
        @(posedge clk); #1;
        check("t1_alu_a", 32'(alu_a), 32'd10);
        check("t1_alu_b", 32'(alu_b), 32'd5);
        check("t1_alu_op", 32'(alu_op_code), 32'd0);
        check("t1_valid_n1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_n2", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_n3", 32'(rsp_valid), 32'd1);
        wait_idle("t1_drain");

        // 2: wrap-around arithmetic, back-to-back
        send(8'd255, 8'd1, 2'b00, 8'd0, 1'b0, w);
        check("t2_wait0", 32'(w), 32'd0);
        send(8'd5, 8'd10, 2'b01, 8'd251, 1'b0, w);
        check("t2_wait1", 32'(w), 32'd0);
        wait_idle("t2_drain");

        // 3: logic ops
        send(8'hAA, 8'hCC, 2'b10, 8'h88, 1'b0, w);
        send(8'hAA, 8'hCC, 2'b11, 8'hEE, 1'b0, w);
        wait_idle("t3_drain");

        // 4: backpressure fills the FIFO
        rsp_ready = 1'b0;
        send(8'd1, 8'd2, 2'b00, 8'd3, 1'b0, w);
        send(8'd9, 8'd4, 2'b01, 8'd5, 1'b0, w);
        send(8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, w);
        send(8'h0F, 8'h30, 2'b11, 8'h3F, 1'b0, w);
        send(8'd200, 8'd100, 2'b00, 8'd44, 1'b0, w);
        check("t4_wait5", 32'(w), 32'd0);
        check("t4_full_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1;
        cmd_a     = 8'd3;
        cmd_b     = 8'd3;
        cmd_op    = 2'b01;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_blocked", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(8'd3, 8'd3, 2'b01, 8'd0, 1'b0, w);
        wait_idle("t4_drain");

        // 5: reset mid-DRIVE drops in-flight and queued work
        send(8'd1, 8'd1, 2'b00, 8'd2, 1'b0, w);
        send(8'd2, 8'd2, 2'b00, 8'd4, 1'b0, w);
        send(8'd3, 8'd3, 2'b00, 8'd6, 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_err = 8'd0;
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("t5_alu", {alu_a, alu_b, 6'd0, alu_op_code, 8'd0}, 32'd0);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) stale++;
        end
        check("t5_no_stale", 32'(stale), 32'd0);
        @(posedge clk); #1;

`ifdef ALU_CHECK_EN
        // 6: reference-model mismatch detection
        force_zero = 1'b1;
        send(8'd7, 8'd3, 2'b00, 8'd0, 1'b1, w);
        wait_idle("t6_drain_bad");
        force_zero = 1'b0;
        check("t6_err_after_bad", 32'(err_count), 32'd1);
        send(8'd4, 8'd4, 2'b00, 8'd8, 1'b0, w);
        wait_idle("t6_drain_good");
        check("t6_err_after_good", 32'(err_count), 32'd1);
        check("t6_mis_after_good", 32'(rsp_mismatch), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
